// File: rtl/cmd_tx.sv
// rtl/cmd_tx.sv - response packet transmitter for the host command link
//
// crc8   : combinational CRC-8 step, poly x^8+x^2+x+1 (8'h07), MSB first,
//          no reflection, no final xor.
//   i_data  in  8  byte to fold in
//   i_crc   in  8  running CRC
//   o_crc   out 8  updated CRC
//
// cmd_tx : serializes one memory request descriptor into a framed response
//          START, OP, SZ, A0..A3, HCRC [, N data bytes, DCRC for MREAD].
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_mreq_valid / o_mreq_ready     descriptor handshake
//   i_mreq_wr, i_mreq_wsize,
//   i_mreq_aincr, i_mreq_size,
//   i_mreq_addr                     descriptor fields, captured on handshake
//   i_tx_valid / o_tx_ready,
//   i_tx_data                       read data byte stream (MREAD only)
//   o_st_valid / i_st_ready,
//   o_st_data                       outgoing byte stream
//   o_busy                          packet in progress

module crc8 (
  input  logic [7:0] i_data,
  input  logic [7:0] i_crc,
  output logic [7:0] o_crc
);

  logic [7:0] c;

  always_comb begin
    c = i_crc ^ i_data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    o_crc = c;
  end

endmodule

module cmd_tx #(
  parameter logic [7:0] P_START = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mreq_valid,
  output logic        o_mreq_ready,
  input  logic        i_mreq_wr,
  input  logic [1:0]  i_mreq_wsize,
  input  logic        i_mreq_aincr,
  input  logic [7:0]  i_mreq_size,
  input  logic [31:0] i_mreq_addr,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_data,
  output logic        o_tx_ready,
  output logic        o_st_valid,
  output logic [7:0]  o_st_data,
  input  logic        i_st_ready,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_DCRC = 2'd3
  } state_t;

  state_t state, state_nx;

  // Captured descriptor
  logic        wr_q;
  logic [1:0]  wsize_q;
  logic        aincr_q;
  logic [7:0]  size_q;
  logic [31:0] addr_q;
  logic [10:0] n_q;        // data byte count, 1..1024

  logic [2:0]  hdr_idx;    // index of the next header byte to load
  logic [10:0] data_cnt;   // data bytes already loaded this packet
  logic [7:0]  crc_q;      // shared accumulator: header CRC, then data CRC

  logic        load_ok;
  logic        mreq_hs;
  logic        tx_hs;
  logic        last_data;
  logic [7:0]  hdr_byte;
  logic [7:0]  crc_data;
  logic [7:0]  crc_in;
  logic [7:0]  crc_out;
  logic [10:0] words;
  logic [10:0] n_d;

  // Output register may take a new byte when empty or being drained.
  assign load_ok   = !o_st_valid || i_st_ready;
  assign mreq_hs   = i_mreq_valid && o_mreq_ready;
  assign tx_hs     = i_tx_valid && o_tx_ready;
  assign last_data = (data_cnt == (n_q - 11'd1));

  // Byte count from the live inputs, registered alongside the descriptor.
  assign words = {3'b000, i_mreq_size} + 11'd1;
  always_comb begin
    n_d = words;
    case (i_mreq_wsize)
      2'd1:    n_d = words << 1;
      2'd2:    n_d = words << 2;
      default: n_d = words;
    endcase
  end

  always_comb begin
    hdr_byte = P_START;
    case (hdr_idx)
      3'd0: hdr_byte = P_START;
      3'd1: hdr_byte = {2'b00, wsize_q, aincr_q, 2'b00, wr_q};
      3'd2: hdr_byte = size_q;
      3'd3: hdr_byte = addr_q[7:0];
      3'd4: hdr_byte = addr_q[15:8];
      3'd5: hdr_byte = addr_q[23:16];
      3'd6: hdr_byte = addr_q[31:24];
      3'd7: hdr_byte = crc_q;
      default: hdr_byte = P_START;
    endcase
  end

  // In IDLE the START byte may be loaded on the handshake edge itself, so the
  // CRC step is fed START with a fresh seed there.
  always_comb begin
    crc_data = hdr_byte;
    crc_in   = crc_q;
    case (state)
      S_IDLE: begin
        crc_data = P_START;
        crc_in   = 8'h00;
      end
      S_DATA:  crc_data = i_tx_data;
      default: crc_data = hdr_byte;
    endcase
  end

  crc8 u_crc8 (
    .i_data (crc_data),
    .i_crc  (crc_in),
    .o_crc  (crc_out)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (mreq_hs) state_nx = S_HDR;
      S_HDR:  if (load_ok && (hdr_idx == 3'd7)) state_nx = wr_q ? S_IDLE : S_DATA;
      S_DATA: if (tx_hs && last_data) state_nx = S_DCRC;
      S_DCRC: if (load_ok) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_mreq_ready = (state == S_IDLE) && !i_rst;
    o_tx_ready   = (state == S_DATA) && load_ok && !i_rst;
    o_busy       = (state != S_IDLE);
  end

  // Descriptor capture, header/data sequencing and the output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q       <= 1'b0;
      wsize_q    <= 2'd0;
      aincr_q    <= 1'b0;
      size_q     <= 8'h00;
      addr_q     <= 32'h0;
      n_q        <= 11'd1;
      hdr_idx    <= 3'd0;
      data_cnt   <= 11'd0;
      crc_q      <= 8'h00;
      o_st_valid <= 1'b0;
      o_st_data  <= 8'h00;
    end else begin
      if (o_st_valid && i_st_ready) o_st_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (mreq_hs) begin
            wr_q     <= i_mreq_wr;
            wsize_q  <= i_mreq_wsize;
            aincr_q  <= i_mreq_aincr;
            size_q   <= i_mreq_size;
            addr_q   <= i_mreq_addr;
            n_q      <= n_d;
            data_cnt <= 11'd0;
            if (load_ok) begin
              o_st_valid <= 1'b1;
              o_st_data  <= P_START;
              crc_q      <= crc_out;
              hdr_idx    <= 3'd1;
            end else begin
              // Previous packet's last byte still held: START waits in HDR.
              crc_q   <= 8'h00;
              hdr_idx <= 3'd0;
            end
          end
        end
        S_HDR: begin
          if (load_ok) begin
            o_st_valid <= 1'b1;
            o_st_data  <= hdr_byte;
            hdr_idx    <= hdr_idx + 3'd1;
            // After HCRC goes out the accumulator restarts for the data CRC.
            crc_q      <= (hdr_idx == 3'd7) ? 8'h00 : crc_out;
          end
        end
        S_DATA: begin
          if (tx_hs) begin
            o_st_valid <= 1'b1;
            o_st_data  <= i_tx_data;
            crc_q      <= crc_out;
            data_cnt   <= data_cnt + 11'd1;
          end
        end
        S_DCRC: begin
          if (load_ok) begin
            o_st_valid <= 1'b1;
            o_st_data  <= crc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_tx.sv
// tb/tb_cmd_tx.sv - directed self-checking bench for cmd_tx
module tb_cmd_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mreq_valid = 1'b0;
  logic        mreq_ready;
  logic        mreq_wr = 1'b0;
  logic [1:0]  mreq_wsize = 2'd0;
  logic        mreq_aincr = 1'b0;
  logic [7:0]  mreq_size = 8'h00;
  logic [31:0] mreq_addr = 32'h0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready;
  logic        st_valid;
  logic [7:0]  st_data;
  logic        st_ready = 1'b1;
  logic        busy;

  cmd_tx #(.P_START(8'hA5)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mreq_valid (mreq_valid),
    .o_mreq_ready (mreq_ready),
    .i_mreq_wr    (mreq_wr),
    .i_mreq_wsize (mreq_wsize),
    .i_mreq_aincr (mreq_aincr),
    .i_mreq_size  (mreq_size),
    .i_mreq_addr  (mreq_addr),
    .i_tx_valid   (tx_valid),
    .i_tx_data    (tx_data),
    .o_tx_ready   (tx_ready),
    .o_st_valid   (st_valid),
    .o_st_data    (st_data),
    .i_st_ready   (st_ready),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int src_idx = 0;
  int tx_hs = 0;
  int tx_rdy_seen = 0;
  bit bp = 1'b0;
  bit stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] out_q[$];
  int         out_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] chain(input int lo, input int hi);
    logic [7:0] c;
    c = 8'h00;
    for (int i = lo; i < hi; i++) c = crc_step(c, out_q[i]);
    return c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream/read-data driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      st_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      tx_data  = (src_idx < src_q.size()) ? src_q[src_idx] : 8'hEE;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) check("hold", {23'd0, st_valid, st_data}, {23'd0, 1'b1, prev_data});
      if (st_valid && st_ready) begin
        out_q.push_back(st_data);
        out_cyc.push_back(cyc);
      end
      if (tx_valid && tx_ready) begin
        src_idx++;
        tx_hs++;
      end
      if (tx_ready) tx_rdy_seen++;
    end
    stall_prev = st_valid && !st_ready && !rst;
    prev_data  = st_data;
  end

  task automatic clear_run();
    out_q.delete();
    out_cyc.delete();
    src_idx = 0;
    tx_hs = 0;
    tx_rdy_seen = 0;
  endtask

  task automatic send(input logic wr, input logic [1:0] ws, input logic ai,
                      input logic [7:0] sz, input logic [31:0] ad);
    bit got;
    @(posedge clk);
    #1;
    mreq_wr = wr; mreq_wsize = ws; mreq_aincr = ai; mreq_size = sz; mreq_addr = ad;
    mreq_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (mreq_ready) begin
        got = 1'b1;
        hs_cyc = cyc;
      end else @(posedge clk);
    end
    if (!got) check("mreq_hs_timeout", 0, 1);
    @(posedge clk);
    #1;
    // Scramble the inputs: the packet in flight must not follow them.
    mreq_valid = 1'b0; mreq_wr = ~wr; mreq_wsize = ws + 2'd1; mreq_aincr = ~ai;
    mreq_size = 8'h77; mreq_addr = 32'hDEADDEAD;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (!busy && !st_valid) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic build_exp(input logic wr, input logic [1:0] ws, input logic ai,
                           input logic [7:0] sz, input logic [31:0] ad);
    logic [7:0] c;
    int bpw;
    int n;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back({2'b00, ws, ai, 2'b00, wr});
    exp_q.push_back(sz);
    exp_q.push_back(ad[7:0]);
    exp_q.push_back(ad[15:8]);
    exp_q.push_back(ad[23:16]);
    exp_q.push_back(ad[31:24]);
    c = 8'h00;
    for (int i = 0; i < 7; i++) c = crc_step(c, exp_q[i]);
    exp_q.push_back(c);
    if (!wr) begin
      bpw = (ws == 2'd1) ? 2 : (ws == 2'd2) ? 4 : 1;
      n = bpw * (int'(sz) + 1);
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(src_q[i]);
        c = crc_step(c, src_q[i]);
      end
      exp_q.push_back(c);
    end
  endtask

  task automatic cmp_pkt(input string name);
    check({name, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", name, i), {24'd0, out_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic set_src3();
    src_q.delete();
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_st_valid", {31'd0, st_valid}, 0);
    check("rst_st_data", {24'd0, st_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_mreq_ready", {31'd0, mreq_ready}, 0);
    check("rst_tx_ready", {31'd0, tx_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_mreq_ready", {31'd0, mreq_ready}, 1);

    // 1: MWRITE header only, hand-computed header bytes
    clear_run();
    src_q.delete();
    send(1'b1, 2'd2, 1'b1, 8'h03, 32'h12345678);
    wait_idle(100);
    exp_q.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h29); exp_q.push_back(8'h03);
    exp_q.push_back(8'h78); exp_q.push_back(8'h56); exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    exp_q.push_back(crc_step(crc_step(crc_step(crc_step(crc_step(crc_step(crc_step(
      8'h00, 8'hA5), 8'h29), 8'h03), 8'h78), 8'h56), 8'h34), 8'h12));
    cmp_pkt("mwr");
    check("mwr_chain", {24'd0, chain(0, out_q.size())}, 0);
    check("mwr_tx_ready_seen", 32'(tx_rdy_seen), 0);
    if (out_cyc.size() == 8) begin
      check("mwr_latency", 32'(out_cyc[0]), 32'(hs_cyc + 1));
      check("mwr_gapless", 32'(out_cyc[7] - out_cyc[0]), 7);
    end

    // 2: MREAD, 1-byte words
    clear_run();
    set_src3();
    send(1'b0, 2'd0, 1'b0, 8'h02, 32'h00000100);
    wait_idle(100);
    build_exp(1'b0, 2'd0, 1'b0, 8'h02, 32'h00000100);
    check("mrd_op", {24'd0, exp_q[1]}, 32'h00);
    cmp_pkt("mrd");
    if (out_q.size() == 12) check("mrd_dchain", {24'd0, chain(8, 12)}, 0);
    check("mrd_tx_hs", 32'(tx_hs), 3);
    if (out_cyc.size() == 12) check("mrd_gapless", 32'(out_cyc[11] - out_cyc[0]), 11);

    // 2b: 4-byte MREAD occupies 13 consecutive cycles
    clear_run();
    src_q.delete();
    src_q.push_back(8'hC0); src_q.push_back(8'hFF); src_q.push_back(8'hEE); src_q.push_back(8'h01);
    send(1'b0, 2'd2, 1'b0, 8'h00, 32'hA0B0C0D0);
    wait_idle(100);
    build_exp(1'b0, 2'd2, 1'b0, 8'h00, 32'hA0B0C0D0);
    cmp_pkt("mrd4");
    if (out_cyc.size() == 13) check("mrd4_gapless", 32'(out_cyc[12] - out_cyc[0]), 12);

    // 3: backpressure and read-data gaps
    clear_run();
    set_src3();
    bp = 1'b1;
    send(1'b0, 2'd0, 1'b0, 8'h02, 32'h00000100);
    wait_idle(400);
    bp = 1'b0;
    build_exp(1'b0, 2'd0, 1'b0, 8'h02, 32'h00000100);
    cmp_pkt("bp");
    check("bp_tx_hs", 32'(tx_hs), 3);

    // 4: maximum size, 1024 data bytes
    clear_run();
    src_q.delete();
    for (int i = 0; i < 1024; i++) src_q.push_back(8'(i) ^ 8'h5A);
    send(1'b0, 2'd2, 1'b1, 8'hFF, 32'h80000000);
    wait_idle(2000);
    build_exp(1'b0, 2'd2, 1'b1, 8'hFF, 32'h80000000);
    check("max_exp_len", 32'(exp_q.size()), 1033);
    cmp_pkt("max");
    repeat (5) @(negedge clk);
    check("max_tx_hs", 32'(tx_hs), 1024);

    // 5: reset during data byte 2
    clear_run();
    set_src3();
    send(1'b0, 2'd0, 1'b0, 8'h02, 32'h00000100);
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
        @(negedge clk);
        if (tx_hs >= 2) hit = 1'b1;
      end
      if (!hit) check("rstmid_timeout", 0, 1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_st_valid", {31'd0, st_valid}, 0);
    check("rstmid_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_mreq_ready", {31'd0, mreq_ready}, 1);
    clear_run();
    send(1'b0, 2'd0, 1'b0, 8'h02, 32'h00000100);
    wait_idle(100);
    build_exp(1'b0, 2'd0, 1'b0, 8'h02, 32'h00000100);
    cmp_pkt("rstmid_next");

    // 6: decode MWRITE packets as the receiving parser would
    for (int p = 0; p < 2; p++) begin
      logic [1:0]  ws;
      logic        ai;
      logic [7:0]  sz;
      logic [31:0] ad;
      ws = (p == 0) ? 2'd1 : 2'd3;
      ai = (p == 0) ? 1'b0 : 1'b1;
      sz = (p == 0) ? 8'h00 : 8'h80;
      ad = (p == 0) ? 32'hDEADBEEF : 32'h0000FFFF;
      clear_run();
      send(1'b1, ws, ai, sz, ad);
      wait_idle(100);
      check("lb_len", 32'(out_q.size()), 8);
      if (out_q.size() == 8) begin
        check("lb_start", {24'd0, out_q[0]}, 32'hA5);
        check("lb_wr", {31'd0, out_q[1][0]}, 1);
        check("lb_wsize", {30'd0, out_q[1][5:4]}, {30'd0, ws});
        check("lb_aincr", {31'd0, out_q[1][3]}, {31'd0, ai});
        check("lb_size", {24'd0, out_q[2]}, {24'd0, sz});
        check("lb_addr", {out_q[6], out_q[5], out_q[4], out_q[3]}, ad);
        check("lb_crc_err", {31'd0, chain(0, 8) != 8'h00}, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
